// File: rtl/reg_status_file_pkg.sv
// rtl/reg_status_file_pkg.sv - shared widths for the architectural register file
package reg_status_file_pkg;

    localparam int REG_NUM    = 32;
    localparam int DATA_WIDTH = 32;
    localparam int REG_WIDTH  = 5;
    localparam int TAG_WIDTH  = 3;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [REG_WIDTH-1:0]  reg_idx_t;
    typedef logic [TAG_WIDTH-1:0]  tag_t;

endpackage

// File: rtl/reg_status_file_if.sv
// rtl/reg_status_file_if.sv - decoder/commit bus of the architectural register file
interface reg_status_file_if;
    import reg_status_file_pkg::*;

    logic     flush;
    logic     lock_en;
    reg_idx_t lock_reg;
    tag_t     lock_entry;
    logic     reg_modify;
    reg_idx_t reg_name;
    data_t    reg_data;
    tag_t     reg_entry;
    reg_idx_t rd_reg1;
    reg_idx_t rd_reg2;
    data_t    rd_value1;
    data_t    rd_value2;
    logic     rd_busy1;
    logic     rd_busy2;
    tag_t     rd_tag1;
    tag_t     rd_tag2;

    modport master (
        output flush, lock_en, lock_reg, lock_entry,
        output reg_modify, reg_name, reg_data, reg_entry,
        output rd_reg1, rd_reg2,
        input  rd_value1, rd_value2, rd_busy1, rd_busy2, rd_tag1, rd_tag2
    );

    modport slave (
        input  flush, lock_en, lock_reg, lock_entry,
        input  reg_modify, reg_name, reg_data, reg_entry,
        input  rd_reg1, rd_reg2,
        output rd_value1, rd_value2, rd_busy1, rd_busy2, rd_tag1, rd_tag2
    );

endinterface

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - one operand read port with same-cycle commit bypass
module reg_read_port
    import reg_status_file_pkg::*;
(
    input  reg_idx_t rd_reg_i,
    input  data_t    data_i,
    input  logic     busy_i,
    input  tag_t     tag_i,
    input  logic     commit_en_i,
    input  reg_idx_t commit_reg_i,
    input  data_t    commit_data_i,
    input  tag_t     commit_entry_i,
    output data_t    rd_value_o,
    output logic     rd_busy_o,
    output tag_t     rd_tag_o
);

    logic bypass;

    // A retiring value counts only if it is the producer the register waits on;
    // register 0 never bypasses so it always reads as zero.
    always_comb begin
        bypass     = commit_en_i && (commit_reg_i == rd_reg_i) &&
                     (rd_reg_i != '0) && (commit_entry_i == tag_i);
        rd_value_o = bypass ? commit_data_i : data_i;
        rd_busy_o  = bypass ? 1'b0 : busy_i;
        rd_tag_o   = tag_i;
    end

endmodule

// File: rtl/reg_status_file.sv
// rtl/reg_status_file.sv - architectural registers with per-register rename status
module reg_status_file
    import reg_status_file_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    reg_status_file_if.slave   bus
);

    data_t              data_q [REG_NUM];
    data_t              data_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    tag_t               tag_q  [REG_NUM];
    tag_t               tag_d  [REG_NUM];

    logic commit_ok;
    logic lock_ok;

    // Next state: commit writes data, then flush or lock override the busy/tag view.
    always_comb begin
        data_d    = data_q;
        busy_d    = busy_q;
        tag_d     = tag_q;
        commit_ok = bus.reg_modify && (bus.reg_name != '0);
        lock_ok   = bus.lock_en && (bus.lock_reg != '0);
        if (commit_ok) begin
            data_d[bus.reg_name] = bus.reg_data;
        end
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            // A mismatched tag means a younger writer still owns the register.
            if (commit_ok && (tag_q[bus.reg_name] == bus.reg_entry)) begin
                busy_d[bus.reg_name] = 1'b0;
            end
            if (lock_ok) begin
                busy_d[bus.lock_reg] = 1'b1;
                tag_d[bus.lock_reg]  = bus.lock_entry;
            end
        end
    end

    // State registers; reset clears everything, register 0 is never written otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            busy_q <= busy_d;
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

    reg_read_port u_rd1 (
        .rd_reg_i       (bus.rd_reg1),
        .data_i         (data_q[bus.rd_reg1]),
        .busy_i         (busy_q[bus.rd_reg1]),
        .tag_i          (tag_q[bus.rd_reg1]),
        .commit_en_i    (bus.reg_modify),
        .commit_reg_i   (bus.reg_name),
        .commit_data_i  (bus.reg_data),
        .commit_entry_i (bus.reg_entry),
        .rd_value_o     (bus.rd_value1),
        .rd_busy_o      (bus.rd_busy1),
        .rd_tag_o       (bus.rd_tag1)
    );

    reg_read_port u_rd2 (
        .rd_reg_i       (bus.rd_reg2),
        .data_i         (data_q[bus.rd_reg2]),
        .busy_i         (busy_q[bus.rd_reg2]),
        .tag_i          (tag_q[bus.rd_reg2]),
        .commit_en_i    (bus.reg_modify),
        .commit_reg_i   (bus.reg_name),
        .commit_data_i  (bus.reg_data),
        .commit_entry_i (bus.reg_entry),
        .rd_value_o     (bus.rd_value2),
        .rd_busy_o      (bus.rd_busy2),
        .rd_tag_o       (bus.rd_tag2)
    );

endmodule

// File: tb/tb_reg_status_file.sv
// tb/tb_reg_status_file.sv - scoreboard bench for reg_status_file
module tb_reg_status_file;

    logic clk;
    logic rst;

    reg_status_file_if bus ();

    reg_status_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] v1;
        logic        b1;
        logic [2:0]  t1;
        logic [31:0] v2;
        logic        b2;
        logic [2:0]  t2;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit model_ok = 0;

    // Reference architectural state
    logic [31:0] m_data [32];
    bit          m_busy [32];
    logic [2:0]  m_tag  [32];

    // What the decoder should see for register q given the inputs of this cycle
    task automatic model_read(input logic [4:0] q, input bit mod, input logic [4:0] nm,
                              input logic [31:0] d, input logic [2:0] ent,
                              output logic [31:0] v, output logic b, output logic [2:0] t);
        if (q == 0) begin
            v = 0; b = 0; t = 0;
        end else if (mod && nm == q && m_tag[q] == ent) begin
            v = d; b = 0; t = m_tag[q];
        end else begin
            v = m_data[q]; b = m_busy[q]; t = m_tag[q];
        end
    endtask

    task automatic step(input bit r, input bit fl, input bit le, input logic [4:0] lr,
                        input logic [2:0] lt, input bit mod, input logic [4:0] nm,
                        input logic [31:0] d, input logic [2:0] ent,
                        input logic [4:0] q1, input logic [4:0] q2);
        exp_t e;
        bit   match;
        @(posedge clk);
        #1;
        rst            = r;
        bus.flush      = fl;
        bus.lock_en    = le;
        bus.lock_reg   = lr;
        bus.lock_entry = lt;
        bus.reg_modify = mod;
        bus.reg_name   = nm;
        bus.reg_data   = d;
        bus.reg_entry  = ent;
        bus.rd_reg1    = q1;
        bus.rd_reg2    = q2;
        cyc++;
        if (model_ok) begin
            e.cyc = cyc; e.r1 = q1; e.r2 = q2;
            model_read(q1, mod, nm, d, ent, e.v1, e.b1, e.t1);
            model_read(q2, mod, nm, d, ent, e.v2, e.b2, e.t2);
            exp_q.push_back(e);
        end
        // Architectural effect of this cycle's edge
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
            model_ok = 1;
        end else begin
            match = mod && nm != 0 && m_tag[nm] == ent;
            if (mod && nm != 0) m_data[nm] = d;
            if (fl) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else begin
                if (match) m_busy[nm] = 0;
                if (le && lr != 0) begin
                    m_busy[lr] = 1;
                    m_tag[lr]  = lt;
                end
            end
        end
    endtask

    task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
    endtask

    // Monitor: read outputs are live every cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.rd_value1 !== e.v1 || bus.rd_busy1 !== e.b1 || bus.rd_tag1 !== e.t1 ||
                    bus.rd_value2 !== e.v2 || bus.rd_busy2 !== e.b2 || bus.rd_tag2 !== e.t2) begin
                    failures++;
                    $display("FAIL read cyc=%0d r%0d/r%0d got v=%h b=%0d t=%0d / v=%h b=%0d t=%0d want v=%h b=%0d t=%0d / v=%h b=%0d t=%0d",
                             e.cyc, e.r1, e.r2,
                             bus.rd_value1, bus.rd_busy1, bus.rd_tag1,
                             bus.rd_value2, bus.rd_busy2, bus.rd_tag2,
                             e.v1, e.b1, e.t1, e.v2, e.b2, e.t2);
                end
            end
        end
    end

    initial begin
        int drain;
        rst = 1; bus.flush = 0; bus.lock_en = 0; bus.lock_reg = 0; bus.lock_entry = 0;
        bus.reg_modify = 0; bus.reg_name = 0; bus.reg_data = 0; bus.reg_entry = 0;
        bus.rd_reg1 = 0; bus.rd_reg2 = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        idle(5, 0);
        idle(0, 5);
        // Lock then matching commit with bypass
        step(0, 0, 1, 3, 2, 0, 0, 0, 0, 3, 3);
        idle(3, 0);
        step(0, 0, 0, 0, 0, 1, 3, 32'h1234, 2, 3, 3);
        idle(3, 3);
        // Stale commit leaves the younger lock pending
        step(0, 0, 1, 4, 1, 0, 0, 0, 0, 4, 0);
        step(0, 0, 1, 4, 5, 0, 0, 0, 0, 4, 0);
        step(0, 0, 0, 0, 0, 1, 4, 32'hAA, 1, 4, 4);
        idle(4, 4);
        // Commit and relock in the same cycle
        step(0, 0, 1, 6, 3, 0, 0, 0, 0, 6, 0);
        step(0, 0, 1, 6, 7, 1, 6, 32'h55, 3, 6, 6);
        idle(6, 6);
        // Register 0 ignores everything
        step(0, 0, 1, 0, 4, 1, 0, 32'hFFFF, 0, 0, 0);
        idle(0, 0);
        // Flush drops busy bits and the concurrent lock
        step(0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 2);
        step(0, 0, 1, 2, 2, 0, 0, 0, 0, 1, 2);
        step(0, 0, 1, 7, 3, 0, 0, 0, 0, 7, 8);
        step(0, 1, 1, 8, 4, 0, 0, 0, 0, 1, 8);
        idle(1, 2);
        idle(7, 8);
        idle(3, 6);

        // Random traffic on a small register window so tags collide often
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)),
                 3'($urandom()),
                 $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)),
                 $urandom(),
                 3'($urandom()),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 31)));
        end
        idle(0, 0);

        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_status_file.md
# reg_status_file

Architectural register file with per-register rename status for the Tomasulo pipeline. The ROB commit stage writes retired results through it. The decoder reads operands from it and locks destination registers to ROB entries in it. Each of the 32 registers holds a data word, a busy bit and the ROB entry that will produce its next value. Operand reads are combinational and include same-cycle commit bypass, so the decoder can issue in the cycle a value retires.

## Interface
Parameters:
- REG_NUM, 32: number of architectural registers; register 0 is hardwired to zero.
- DATA_WIDTH, `Data_Width (32): register data width.
- REG_WIDTH, `Reg_Width (5): register index width.
- TAG_WIDTH, `ROB_Entry_Width (3): ROB entry tag width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  clears every busy bit on the next edge. Data is kept.
- lock_en  in  1  decoder claims a destination register.
- lock_reg  in  REG_WIDTH  destination register index.
- lock_entry  in  TAG_WIDTH  ROB entry assigned to the destination (ROB out_lock).
- reg_modify  in  1  ROB commit strobe.
- reg_name  in  REG_WIDTH  committed register index.
- reg_data  in  DATA_WIDTH  committed value.
- reg_entry  in  TAG_WIDTH  ROB entry being retired.
- rd_reg1, rd_reg2  in  REG_WIDTH  decoder operand indices.
- rd_value1, rd_value2  out  DATA_WIDTH  operand value (valid when busy is 0).
- rd_busy1, rd_busy2  out  1  operand awaits an in-flight ROB entry.
- rd_tag1, rd_tag2  out  TAG_WIDTH  ROB entry to wait on, or to query through check_entry.

## Operation
- State per register r: data[r], busy[r], tag[r].
- Commit (reg_modify=1, reg_name≠0): data[reg_name] ← reg_data unconditionally. busy[reg_name] ← 0 only if tag[reg_name]==reg_entry and no lock to the same register this cycle. On a tag mismatch the data is still written and busy stays set, because a younger writer is pending.
- Lock (lock_en=1, lock_reg≠0): busy[lock_reg] ← 1, tag[lock_reg] ← lock_entry.
- Lock and commit to the same register in one cycle: data written, lock wins (busy=1, tag=lock_entry).
- Register 0: commits and locks are ignored. Reads return value 0, busy 0, tag 0.
- Read port n (combinational), for reg index q = rd_regn:
  - If a commit targets q with a matching tag: value=reg_data, busy=0, tag=tag[q].
  - Otherwise: value=data[q], busy=busy[q], tag=tag[q].
- A same-cycle lock is never visible to reads. The instruction issuing the lock reads its sources before its own destination claim (add r1,r1,r2 reads old r1).
- flush: all busy bits ← 0 and any lock that cycle is dropped. A commit in the same cycle still writes its data.
- Priority per edge: rst > flush > lock > commit for busy/tag. Data is written by commit and by rst only.

## Timing
- Reset: data, busy and tag all 0 for every register on the first edge with rst=1. Read outputs are then value=0, busy=0, tag=0 for any index.
- Reads have zero latency; outputs are pure functions of rd_reg and current state plus commit inputs.
- Commit and lock take effect on the edge they are presented, visible to reads the following cycle. The commit bypass covers the same cycle.
- No handshake or backpressure: every request presented is accepted in that cycle.
- Tag wrap-around: tags are compared by equality only. A stale commit whose entry number was reused is harmless because the ROB retires in order.
- rst asserted mid-operation discards all pending locks; concurrent lock and commit inputs are ignored.

## Structure
- `Data_Width`, `Reg_Width`, `ROB_Entry_Width` and a new `Reg_Num` (32) belong in the shared defines file, alongside the ROB interval macros.
- One sub-module is natural: reg_read_port. It implements the commit-bypass mux for one read port and is instantiated twice. The state arrays and update logic stay in reg_status_file.

## Test plan
- Reset, then read r5 and r0 → value 0, busy 0, tag 0 on both ports.
- Lock r3 to entry 2; next cycle read r3 → busy 1, tag 2. Commit r3 with entry 2, data 0x1234 → same-cycle read gives value 0x1234, busy 0; next cycle busy 0.
- Lock r4 to entry 1, then to entry 5. Commit r4 entry 1, data 0xAA → data 0xAA, busy stays 1, tag 5.
- In one cycle, commit r6 entry 3 (tag 3, data 0x55) and lock r6 to entry 7, reading r6 → read shows value 0x55, busy 0. Next cycle: busy 1, tag 7, data 0x55.
- Lock and commit r0 with data 0xFFFF → r0 reads 0, busy 0.
- Lock r1, r2 and r7; assert flush together with a lock of r8 → next cycle all busy 0, r8 not busy, data unchanged.
